reg_bank: RTL and testbench
===========================

REG_BANK -- requirements
Module: reg_bank

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, number of 64-bit registers.
REQ-002 SHALL have parameter DATA_W, default 64, register width in bits.
REQ-003 SHALL have parameter ZERO_REG, default 31, index of the hardwired-zero register.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  write request, sampled on the rising edge of clk.
REQ-007 SHALL have port wr_addr  input  5  destination register index.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port regs_out  output  [NUM_REGS-1:0][DATA_W-1:0]  all register contents, packed so it drives the 32:1 read-select mux dataIn directly.
REQ-010 SHALL have port busy  output  1  a write is pending in the buffer.
REQ-011 SHALL have port wr_count  output  16  committed-write counter.

Function
REQ-012 SHALL capture wr_en, wr_addr, wr_data into a one-entry pending buffer (pend_vld, pend_addr, pend_data) on every rising edge; pend_vld follows wr_en.
REQ-013 SHALL commit pend_data to regs[pend_addr] on the next rising edge when pend_vld=1 and pend_addr!=ZERO_REG (two edges from request to array).
REQ-014 SHALL drop writes to ZERO_REG at commit: no array change, no wr_count increment.
REQ-015 SHALL keep regs_out[ZERO_REG] = 0 at all times.
REQ-016 SHALL drive regs_out from the committed array for all other entries, except as in REQ-023.
REQ-017 SHALL drive busy = pend_vld.
REQ-018 SHALL increment wr_count by 1 for each non-dropped commit and saturate at 16'hFFFF.
REQ-019 SHALL accept back-to-back writes every cycle with no stall; writes to the same address commit in order, so the last one wins.
REQ-020 SHALL treat the capture of write N+1 and the commit of write N on the same edge as independent, with no loss.

Reset
REQ-021 SHALL, while reset=1, force all registers, pend_vld, pend_addr, pend_data and wr_count to 0 immediately, without waiting for a clock edge; busy=0 and regs_out=0.
REQ-022 SHALL discard a write in the buffer when reset asserts mid-operation; after reset releases, the first wr_en is captured on the first rising edge.

Configuration
REQ-023 SHALL, with REG_BANK_FWD_EN defined, drive regs_out[pend_addr] = pend_data whenever pend_vld=1 and pend_addr!=ZERO_REG, so pending data is visible one cycle early.
REQ-024 SHALL, without REG_BANK_FWD_EN, show only committed data on regs_out; there is no forwarding logic.

Structure
REQ-025 SHALL take NUM_REGS, DATA_W, ZERO_REG, reg_addr_t (5-bit) and reg_word_t (DATA_W-bit) from shared package reg_bank_pkg.
REQ-026 SHALL decode the commit address with one sub-module, decoder5_32 (5-bit address plus enable to 32-bit one-hot; all zeros when the enable is low).

Verification
REQ-027 Reset then idle -> regs_out all 0, busy=0, wr_count=0.
REQ-028 wr_en=1, wr_addr=3, wr_data=64'hDEAD_BEEF for one cycle -> busy=1 after edge 1; regs_out[3]=64'hDEAD_BEEF after edge 2 (after edge 1 when REG_BANK_FWD_EN is defined); wr_count=1.
REQ-029 Write 64'h1234 to address 31 -> regs_out[31] stays 0; wr_count does not change; busy=1 for one cycle.
REQ-030 Back-to-back writes to address 5 with values 1, 2, 3 -> regs_out[5]=3 at the end; wr_count=3; busy stays high for 3 cycles.
REQ-031 Assert reset asynchronously while busy=1 holding a write to address 7 -> regs_out[7]=0 and busy=0 with no clock edge; no commit after release.
REQ-032 Preload wr_count to 16'hFFFE, then issue 3 valid writes -> wr_count=16'hFFFF and holds there.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared types and constants for the reg_bank register file.
// Forwarding of pending write data is enabled by defining REG_BANK_FWD_EN.
package reg_bank_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned ZERO_REG = 31;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned SEL_W    = 32;
    localparam int unsigned CNT_W    = 16;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_word_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/reg_bank_decoder.sv
// 5-bit address to 32-bit one-hot decoder with enable; all zeros when disabled.
module decoder5_32
    import reg_bank_pkg::*;
(
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_en,
    output logic [SEL_W-1:0]  o_sel_c
);

    always_comb begin
        o_sel_c = '0;
        if (i_en) begin
            o_sel_c[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Register file with a one-entry write buffer, hardwired-zero register and
// saturating commit counter. Define REG_BANK_FWD_EN to expose pending data early.
module reg_bank #(
    parameter int unsigned NUM_REGS = reg_bank_pkg::NUM_REGS,
    parameter int unsigned DATA_W   = reg_bank_pkg::DATA_W,
    parameter int unsigned ZERO_REG = reg_bank_pkg::ZERO_REG
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  wr_en,
    input  logic [reg_bank_pkg::ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]                     wr_data,
    output logic [NUM_REGS-1:0][DATA_W-1:0]       regs_out,
    output logic                                  busy,
    output logic [reg_bank_pkg::CNT_W-1:0]        wr_count
);

    import reg_bank_pkg::*;

    logic                r_pend_vld;
    reg_addr_t           r_pend_addr;
    logic [DATA_W-1:0]   r_pend_data;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [CNT_W-1:0]    r_wr_count;

    logic                w_commit;
    logic [SEL_W-1:0]    w_sel;

    // Writes aimed at the zero register are dropped here, so they never decode.
    assign w_commit = r_pend_vld && (r_pend_addr != ADDR_W'(ZERO_REG));

    decoder5_32 u_dec (
        .i_addr  (r_pend_addr),
        .i_en    (w_commit),
        .o_sel_c (w_sel)
    );

    // Pending buffer recaptures every edge; commit of the previous entry is independent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend_vld  <= 1'b0;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else begin
            r_pend_vld  <= wr_en;
            r_pend_addr <= wr_addr;
            r_pend_data <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_sel[i]) begin
                    r_regs[i] <= r_pend_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_wr_count <= sat_inc(r_wr_count);
        end
    end

    // Read view: committed array, zero register forced low, optional bypass.
    always_comb begin
        regs_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (i != ZERO_REG) begin
                regs_out[i] = r_regs[i];
`ifdef REG_BANK_FWD_EN
                if (r_pend_vld && (r_pend_addr == ADDR_W'(i))) begin
                    regs_out[i] = r_pend_data;
                end
`else
`endif
            end
        end
    end

    assign busy     = r_pend_vld;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: expected commits queued at drive time,
// popped and checked on the edge where the commit lands.
module tb_reg_bank;

    localparam int unsigned NR = 32;
    localparam int unsigned DW = 64;
    localparam logic [4:0]  ZR = 5'd31;

    typedef struct packed {
        logic [4:0]    addr;
        logic [DW-1:0] data;
    } exp_t;

    logic                   clk;
    logic                   reset;
    logic                   wr_en;
    logic [4:0]             wr_addr;
    logic [DW-1:0]          wr_data;
    logic [NR-1:0][DW-1:0]  regs_out;
    logic                   busy;
    logic [15:0]            wr_count;

    int unsigned n_vec;
    int unsigned n_err;
    exp_t        exp_q[$];
    logic        prev_wen;
    logic [15:0] m_count;
    bit          chk_on;

    reg_bank dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .regs_out (regs_out),
        .busy     (busy),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < int'(NR); i++) begin
            check_eq($sformatf("%s_r%0d", tag, i), regs_out[i], '0);
        end
    endtask

    // One clock: present inputs, take the edge, then check what that edge produced.
    task automatic step(input logic wen, input logic [4:0] a, input logic [DW-1:0] d);
        exp_t        e;
        logic [DW-1:0] want;
        wr_en   = wen;
        wr_addr = a;
        wr_data = d;
        @(posedge clk);
        #1;
        if (prev_wen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.addr != ZR && m_count != 16'hFFFF) m_count = m_count + 16'd1;
            want = (e.addr == ZR) ? '0 : e.data;
`ifdef REG_BANK_FWD_EN
            if (wen && a == e.addr && a != ZR) want = d;
`endif
            if (chk_on) check_eq($sformatf("commit_r%0d", e.addr), regs_out[e.addr], want);
        end
        if (wen) exp_q.push_back('{addr: a, data: d});
        prev_wen = wen;
        if (chk_on) begin
            check_eq("busy", DW'(busy), DW'(wen));
            check_eq("wr_count", DW'(wr_count), DW'(m_count));
            check_eq("zero_reg", regs_out[ZR], '0);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        prev_wen = 1'b0;
        m_count  = '0;
        chk_on   = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", DW'(busy), '0);
        check_eq("rst_count", DW'(wr_count), '0);
        check_all_zero("rst");
        #3 reset = 1'b0;
        step(1'b0, '0, '0);

        // Single write to r3
        step(1'b1, 5'd3, 64'hDEAD_BEEF);
`ifdef REG_BANK_FWD_EN
        check_eq("fwd_r3", regs_out[3], 64'hDEAD_BEEF);
`else
        check_eq("nofwd_r3", regs_out[3], '0);
`endif
        step(1'b0, '0, '0);
        check_eq("r3_final", regs_out[3], 64'hDEAD_BEEF);
        check_eq("cnt_after_r3", DW'(wr_count), 64'd1);

        // Write to the zero register is dropped
        step(1'b1, ZR, 64'h1234);
        step(1'b0, '0, '0);
        check_eq("r31_dropped", regs_out[31], '0);
        check_eq("cnt_after_r31", DW'(wr_count), 64'd1);

        // Back-to-back to r5, last wins
        step(1'b1, 5'd5, 64'd1);
        step(1'b1, 5'd5, 64'd2);
        step(1'b1, 5'd5, 64'd3);
        step(1'b0, '0, '0);
        check_eq("r5_last", regs_out[5], 64'd3);
        check_eq("cnt_after_r5", DW'(wr_count), 64'd4);

        // Random traffic including zero-register hits
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                 {32'($urandom), 32'($urandom)});
        end
        step(1'b0, '0, '0);

        // Async reset with a write to r7 pending
        step(1'b1, 5'd7, 64'hCAFE_F00D_0000_0007);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_busy", DW'(busy), '0);
        check_eq("arst_r7", regs_out[7], '0);
        check_eq("arst_count", DW'(wr_count), '0);
        check_all_zero("arst");
        exp_q.delete();
        prev_wen = 1'b0;
        m_count  = '0;
        wr_en    = 1'b0;
        @(posedge clk);
        #3 reset = 1'b0;
        step(1'b0, '0, '0);
        step(1'b0, '0, '0);
        check_eq("post_arst_r7", regs_out[7], '0);
        step(1'b1, 5'd9, 64'h99);
        step(1'b0, '0, '0);
        check_eq("post_arst_r9", regs_out[9], 64'h99);

        // Drive the counter to 16'hFFFE, then saturate
        chk_on = 1'b0;
        for (int i = 0; i < 65533; i++) begin
            step(1'b1, 5'd0, DW'(i));
        end
        step(1'b0, '0, '0);
        chk_on = 1'b1;
        check_eq("cnt_preload", DW'(wr_count), 64'hFFFE);
        step(1'b1, 5'd1, 64'h11);
        step(1'b1, 5'd2, 64'h22);
        step(1'b1, 5'd4, 64'h44);
        step(1'b0, '0, '0);
        check_eq("cnt_sat", DW'(wr_count), 64'hFFFF);
        step(1'b1, 5'd6, 64'h66);
        step(1'b0, '0, '0);
        check_eq("cnt_hold", DW'(wr_count), 64'hFFFF);
        check_eq("r6_after_sat", regs_out[6], 64'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
